// File: rtl/eae_sequencer.sv
// rtl/eae_sequencer.sv - extended arithmetic element sequencer (shifts, multiply, divide, normalize)
// AC:MQ forms a 24-bit word with bit 0 as MSB; one arithmetic step per clock in RUN.
module eae_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [0:2]  op,
   input  logic [0:11] ac_in,
   input  logic [0:11] mq_in,
   input  logic        l_in,
   input  logic [0:11] operand,
   output logic [0:11] ac_out,
   output logic [0:11] mq_out,
   output logic        link_out,
   output logic [0:4]  sc_out,
   output logic        busy,
   output logic        done
);

   localparam logic [0:2] OP_SHL = 3'd1;
   localparam logic [0:2] OP_ASR = 3'd2;
   localparam logic [0:2] OP_LSR = 3'd3;
   localparam logic [0:2] OP_MUY = 3'd4;
   localparam logic [0:2] OP_DVI = 3'd5;
   localparam logic [0:2] OP_NMI = 3'd6;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [0:11] ac_q, ac_d;
   logic [0:11] mq_q, mq_d;
   logic        link_q, link_d;
   logic [0:4]  sc_q, sc_d;
   logic [0:11] opnd_q, opnd_d;
   logic [0:2]  op_q, op_d;

   logic [0:12] mul_sum;
   logic [0:12] div_rem;
   logic [0:12] div_diff;
   logic        div_ge;
   logic [0:23] nmi_next;

   function automatic logic nmi_stop(input logic [0:23] w);
      return (w[0] != w[1]) || (w == 24'd0) || (w == 24'o60000000);
   endfunction

   always_comb begin
      state_d  = state_q;
      ac_d     = ac_q;
      mq_d     = mq_q;
      link_d   = link_q;
      sc_d     = sc_q;
      opnd_d   = opnd_q;
      op_d     = op_q;
      mul_sum  = {1'b0, ac_q} + (mq_q[11] ? {1'b0, opnd_q} : 13'd0);
      div_rem  = {ac_q, mq_q[0]};
      div_ge   = (div_rem >= {1'b0, opnd_q});
      div_diff = div_rem - {1'b0, opnd_q};
      nmi_next = {ac_q[1:11], mq_q, 1'b0};

      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE)
               state_d = S_IDLE;
            if (start) begin
               ac_d    = ac_in;
               mq_d    = mq_in;
               link_d  = l_in;
               opnd_d  = operand;
               op_d    = op;
               sc_d    = 5'd0;
               state_d = S_RUN;
               case (op)
                  OP_SHL: sc_d = operand[7:11];
                  OP_ASR: begin
                     sc_d   = operand[7:11];
                     link_d = ac_in[0];
                  end
                  OP_LSR: begin
                     sc_d   = operand[7:11];
                     link_d = 1'b0;
                  end
                  OP_MUY: begin
                     sc_d   = 5'd11;
                     link_d = 1'b0;
                  end
                  // Divide overflow is decided here; L then doubles as the skip flag in RUN.
                  OP_DVI: begin
                     link_d = (ac_in >= operand);
                     sc_d   = (ac_in >= operand) ? 5'd0 : 5'd11;
                  end
                  OP_NMI: sc_d = 5'd0;
                  default: state_d = S_DONE;
               endcase
            end
         end

         S_RUN: begin
            if (op_q == OP_NMI) begin
               if (nmi_stop({ac_q, mq_q})) begin
                  state_d = S_DONE;
               end else begin
                  {ac_d, mq_d} = nmi_next;
                  sc_d         = sc_q + 5'd1;
                  if (nmi_stop(nmi_next))
                     state_d = S_DONE;
               end
            end else begin
               if (sc_q == 5'd0)
                  state_d = S_DONE;
               else
                  sc_d = sc_q - 5'd1;
               case (op_q)
                  OP_SHL: {link_d, ac_d, mq_d} = {ac_q, mq_q, 1'b0};
                  OP_ASR: {ac_d, mq_d} = {ac_q[0], ac_q, mq_q[0:10]};
                  OP_LSR: {ac_d, mq_d} = {1'b0, ac_q, mq_q[0:10]};
                  OP_MUY: {ac_d, mq_d} = {mul_sum, mq_q[0:10]};
                  OP_DVI: begin
                     if (!link_q) begin
                        ac_d = div_ge ? div_diff[1:12] : div_rem[1:12];
                        mq_d = {mq_q[1:11], div_ge};
                     end
                  end
                  default: state_d = S_DONE;
               endcase
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ac_q    <= 12'd0;
         mq_q    <= 12'd0;
         link_q  <= 1'b0;
         sc_q    <= 5'd0;
         opnd_q  <= 12'd0;
         op_q    <= 3'd0;
      end else begin
         state_q <= state_d;
         ac_q    <= ac_d;
         mq_q    <= mq_d;
         link_q  <= link_d;
         sc_q    <= sc_d;
         opnd_q  <= opnd_d;
         op_q    <= op_d;
      end
   end

   assign ac_out   = ac_q;
   assign mq_out   = mq_q;
   assign link_out = link_q;
   assign sc_out   = sc_q;
   assign busy     = (state_q == S_RUN);
   assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_eae_sequencer.sv
// tb/tb_eae_sequencer.sv - self-checking bench for eae_sequencer
// Directed vector table, multi-cycle corner sequences, and random ops against an arithmetic model.
module tb_eae_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [0:2]  op_i;
   logic [0:11] ac_i;
   logic [0:11] mq_i;
   logic        l_i;
   logic [0:11] opnd_i;
   logic [0:11] ac_o;
   logic [0:11] mq_o;
   logic        link_o;
   logic [0:4]  sc_o;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

   eae_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op_i),
      .ac_in    (ac_i),
      .mq_in    (mq_i),
      .l_in     (l_i),
      .operand  (opnd_i),
      .ac_out   (ac_o),
      .mq_out   (mq_o),
      .link_out (link_o),
      .sc_out   (sc_o),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [11:0] ac;
      logic [11:0] mq;
      logic        l;
      logic [11:0] opnd;
      logic [11:0] e_ac;
      logic [11:0] e_mq;
      logic        e_l;
      logic [4:0]  e_sc;
      int          e_cyc;
      bit          chk_sc;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0o expected %0o (octal)", name, act, exp);
      end
   endtask

   function automatic bit nmi_stop(input longint w);
      return (((w >> 23) & 1) != ((w >> 22) & 1)) || (w == 0) || (w == 64'o60000000);
   endfunction

   // Result of an operation computed straight from its arithmetic definition.
   function automatic void model(input int op, input int ac, input int mq, input int l,
                                 input int opnd, output int e_ac, output int e_mq,
                                 output int e_l, output int e_sc, output int e_cyc,
                                 output bit chk_sc);
      longint w;
      int     n;
      n      = (opnd & 31) + 1;
      w      = (longint'(ac) << 12) | longint'(mq);
      e_l    = l;
      e_sc   = 0;
      e_cyc  = 1;
      chk_sc = 0;
      case (op)
         1: begin
            w      = ((longint'(l) << 24) | w) << n;
            w      = w & 64'h1FF_FFFF;
            e_l    = int'((w >> 24) & 1);
            e_cyc  = n;
            chk_sc = 1;
         end
         2: begin
            if ((ac & 12'o4000) != 0)
               w = w - (64'sd1 << 24);
            w      = w >>> n;
            e_l    = (ac >> 11) & 1;
            e_cyc  = n;
            chk_sc = 1;
         end
         3: begin
            w      = w >> n;
            e_l    = 0;
            e_cyc  = n;
            chk_sc = 1;
         end
         4: begin
            w     = longint'(mq) * longint'(opnd) + longint'(ac);
            e_l   = 0;
            e_cyc = 12;
         end
         5: begin
            if (ac >= opnd) begin
               e_l   = 1;
               e_cyc = 1;
            end else begin
               w     = ((w / opnd) & 64'hFFF) | ((w % opnd) << 12);
               e_l   = 0;
               e_cyc = 12;
            end
         end
         6: begin
            n = 0;
            while (!nmi_stop(w) && n < 40) begin
               w = (w << 1) & 64'hFF_FFFF;
               n++;
            end
            e_sc   = n % 32;
            e_cyc  = (n == 0) ? 1 : n;
            chk_sc = 1;
         end
         default: e_cyc = 0;
      endcase
      w    = w & 64'hFF_FFFF;
      e_ac = int'(w >> 12);
      e_mq = int'(w & 64'hFFF);
   endfunction

   task automatic drive(input logic [2:0] op, input logic [11:0] ac, input logic [11:0] mq,
                        input logic l, input logic [11:0] opnd);
      @(negedge clk);
      op_i   = op;
      ac_i   = ac;
      mq_i   = mq;
      l_i    = l;
      opnd_i = opnd;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic finish_op(input string tag, input logic [11:0] e_ac, input logic [11:0] e_mq,
                            input logic e_l, input logic [4:0] e_sc, input int e_cyc,
                            input bit chk_sc);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, " run_cycles"}, n, e_cyc);
      check({tag, " done"}, done, 1'b1);
      check({tag, " ac"}, ac_o, e_ac);
      check({tag, " mq"}, mq_o, e_mq);
      check({tag, " link"}, link_o, e_l);
      if (chk_sc)
         check({tag, " sc"}, sc_o, e_sc);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " ac"}, ac_o, 12'd0);
      check({tag, " mq"}, mq_o, 12'd0);
      check({tag, " link"}, link_o, 1'b0);
      check({tag, " sc"}, sc_o, 5'd0);
      check({tag, " busy"}, busy, 1'b0);
      check({tag, " done"}, done, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e_ac, e_mq, e_l, e_sc, e_cyc;
      bit chk;
      int gap;
      logic [2:0]  r_op;
      logic [11:0] r_ac, r_mq, r_opnd;
      logic        r_l;

      vecs[0]  = '{3'd1, 12'o0000, 12'o0001, 1'b0, 12'o0002, 12'o0000, 12'o0010, 1'b0, 5'd0, 3, 1'b1};
      vecs[1]  = '{3'd2, 12'o4000, 12'o0000, 1'b0, 12'o0000, 12'o6000, 12'o0000, 1'b1, 5'd0, 1, 1'b1};
      vecs[2]  = '{3'd3, 12'o4000, 12'o0000, 1'b1, 12'o0000, 12'o2000, 12'o0000, 1'b0, 5'd0, 1, 1'b1};
      vecs[3]  = '{3'd4, 12'o0000, 12'o0012, 1'b1, 12'o0014, 12'o0000, 12'o0170, 1'b0, 5'd0, 12, 1'b0};
      vecs[4]  = '{3'd5, 12'o0000, 12'o0144, 1'b1, 12'o0007, 12'o0002, 12'o0016, 1'b0, 5'd0, 12, 1'b0};
      vecs[5]  = '{3'd5, 12'o0010, 12'o1234, 1'b0, 12'o0007, 12'o0010, 12'o1234, 1'b1, 5'd0, 1, 1'b0};
      vecs[6]  = '{3'd6, 12'o0000, 12'o0001, 1'b0, 12'o0000, 12'o2000, 12'o0000, 1'b0, 5'd22, 22, 1'b1};
      vecs[7]  = '{3'd6, 12'o0000, 12'o0000, 1'b1, 12'o0000, 12'o0000, 12'o0000, 1'b1, 5'd0, 1, 1'b1};
      vecs[8]  = '{3'd1, 12'o7777, 12'o7777, 1'b1, 12'o0037, 12'o0000, 12'o0000, 1'b0, 5'd0, 32, 1'b1};
      vecs[9]  = '{3'd3, 12'o7777, 12'o7777, 1'b1, 12'o0037, 12'o0000, 12'o0000, 1'b0, 5'd0, 32, 1'b1};
      vecs[10] = '{3'd5, 12'o0000, 12'o0555, 1'b0, 12'o0000, 12'o0000, 12'o0555, 1'b1, 5'd0, 1, 1'b0};
      vecs[11] = '{3'd4, 12'o7777, 12'o7777, 1'b1, 12'o7777, 12'o7777, 12'o0000, 1'b0, 5'd0, 12, 1'b0};
      vecs[12] = '{3'd6, 12'o6000, 12'o0000, 1'b1, 12'o0000, 12'o6000, 12'o0000, 1'b1, 5'd0, 1, 1'b1};
      vecs[13] = '{3'd6, 12'o7777, 12'o7777, 1'b0, 12'o0000, 12'o6000, 12'o0000, 1'b0, 5'd22, 22, 1'b1};
      vecs[14] = '{3'd0, 12'o1234, 12'o4321, 1'b1, 12'o0005, 12'o1234, 12'o4321, 1'b1, 5'd0, 0, 1'b0};
      vecs[15] = '{3'd7, 12'o0000, 12'o7777, 1'b0, 12'o0001, 12'o0000, 12'o7777, 1'b0, 5'd0, 0, 1'b0};
      vecs[16] = '{3'd2, 12'o4000, 12'o0000, 1'b0, 12'o0037, 12'o7777, 12'o7777, 1'b1, 5'd0, 32, 1'b1};
      vecs[17] = '{3'd6, 12'o2000, 12'o0123, 1'b0, 12'o0000, 12'o2000, 12'o0123, 1'b0, 5'd0, 1, 1'b1};

      reset  = 1'b1;
      start  = 1'b0;
      op_i   = 3'd0;
      ac_i   = 12'd0;
      mq_i   = 12'd0;
      l_i    = 1'b0;
      opnd_i = 12'd0;
      #1;
      check_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 18; i++) begin
         if (i % 2 == 1) begin
            @(posedge clk);
            #1;
         end
         drive(vecs[i].op, vecs[i].ac, vecs[i].mq, vecs[i].l, vecs[i].opnd);
         finish_op($sformatf("vec%0d", i), vecs[i].e_ac, vecs[i].e_mq, vecs[i].e_l,
                   vecs[i].e_sc, vecs[i].e_cyc, vecs[i].chk_sc);
      end

      // A start pulsed while RUN must not disturb the running shift.
      @(posedge clk);
      #1;
      model(1, 12'o1234, 12'o5670, 1, 5, e_ac, e_mq, e_l, e_sc, e_cyc, chk);
      drive(3'd1, 12'o1234, 12'o5670, 1'b1, 12'o0005);
      drive(3'd4, 12'o7777, 12'o7777, 1'b0, 12'o7777);
      check("ignore busy", busy, 1'b1);
      finish_op("ignore", e_ac[11:0], e_mq[11:0], e_l[0], e_sc[4:0], e_cyc - 1, chk);

      // Reset mid-multiply, then a start on the very first edge after release.
      drive(3'd4, 12'o0000, 12'o0012, 1'b1, 12'o0014);
      repeat (5) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_zero("midreset");
      @(negedge clk);
      reset  = 1'b0;
      op_i   = 3'd4;
      ac_i   = 12'o0000;
      mq_i   = 12'o0012;
      l_i    = 1'b1;
      opnd_i = 12'o0014;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("first start busy", busy, 1'b1);
      finish_op("after reset", 12'o0000, 12'o0170, 1'b0, 5'd0, 12, 1'b0);

      for (int k = 0; k < 200; k++) begin
         r_op   = 3'($urandom_range(0, 7));
         r_ac   = 12'($urandom);
         r_mq   = 12'($urandom);
         r_l    = 1'($urandom);
         r_opnd = 12'($urandom);
         if (r_op == 3'd5 && r_opnd != 0 && $urandom_range(0, 3) != 0)
            r_ac = 12'(r_ac % r_opnd);
         if (r_op == 3'd6 && $urandom_range(0, 1) == 1) begin
            r_ac = 12'd0;
            r_mq = 12'($urandom_range(0, 15));
         end
         model(int'(r_op), int'(r_ac), int'(r_mq), int'(r_l), int'(r_opnd),
               e_ac, e_mq, e_l, e_sc, e_cyc, chk);
         drive(r_op, r_ac, r_mq, r_l, r_opnd);
         finish_op($sformatf("rnd%0d op%0d", k, r_op), e_ac[11:0], e_mq[11:0], e_l[0],
                   e_sc[4:0], e_cyc, chk);
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d done drop", k), done, 1'b0);
            check($sformatf("rnd%0d idle busy", k), busy, 1'b0);
            check($sformatf("rnd%0d hold ac", k), ac_o, e_ac[11:0]);
            check($sformatf("rnd%0d hold mq", k), mq_o, e_mq[11:0]);
            check($sformatf("rnd%0d hold link", k), link_o, e_l[0]);
            repeat (gap - 1) @(posedge clk);
            #1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/eae_sequencer.md
EAE_SEQUENCER -- requirements
Module: eae_sequencer

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL have reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have start, input, 1, one-cycle operation request.
REQ-004 SHALL have op, input, [0:2]: 1 SHL, 2 ASR, 3 LSR, 4 MUY, 5 DVI, 6 NMI; 0 and 7 are NOP.
REQ-005 SHALL have ac_in/mq_in, input, [0:11] each, and l_in, input, 1; these are the operand registers, sampled on start.
REQ-006 SHALL have operand, input, [0:11]: multiplier/divisor for MUY/DVI; bits [7:11] are the shift count c for shifts; sampled on start.
REQ-007 SHALL have ac_out/mq_out, output, [0:11], and link_out, output, 1, holding the result registers.
REQ-008 SHALL have sc_out, output, [0:4], the step counter.
REQ-009 SHALL have busy, output, 1, high in RUN.
REQ-010 SHALL have done, output, 1, one-cycle completion strobe.
REQ-011 SHALL number bit 0 as MSB on all buses; AC:MQ forms a 24-bit word with AC[0] as MSB.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE.
REQ-013 SHALL accept start only when busy=0, i.e. in IDLE or DONE; start in RUN SHALL be ignored with no effect.
REQ-014 On an accepted start with op 1-6, SHALL load AC/MQ/L/operand, set the step count, and enter RUN on the same edge.
REQ-015 On an accepted start with op 0 or 7, SHALL load the registers and go directly to DONE.
REQ-016 In RUN, SHALL perform exactly one step per clock; the edge performing the last step SHALL enter DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE unless a new start is accepted.
REQ-018 Outputs SHALL hold their values from DONE until the next accepted start.
REQ-019 SHL SHALL shift L:AC:MQ left c+1 times, with zero into MQ[11] and AC[0] into L.
REQ-020 ASR SHALL shift AC:MQ right c+1 times, with AC[0] replicated and L set to AC[0] at load.
REQ-021 LSR SHALL shift AC:MQ right c+1 times with zero fill, and SHALL clear L.
REQ-022 For shifts, sc_out SHALL count down from c to 0, and SHALL read 0 in DONE.
REQ-023 For shifts with c=31, SHALL perform 32 steps, and AC:MQ SHALL end all-zero for SHL and LSR.
REQ-024 MUY SHALL compute AC:MQ = MQ*operand + AC (unsigned) in 12 shift-add steps, and SHALL clear L.
REQ-025 MUY SHALL produce no overflow, since the maximum result fits in 24 bits.
REQ-026 DVI SHALL check AC >= operand at load; if true it SHALL set L=1, leave AC/MQ unchanged, and take one RUN step.
REQ-027 Otherwise DVI SHALL perform a 12-step restoring division of AC:MQ by operand, leaving quotient in MQ and remainder in AC, with L=0.
REQ-028 DVI by operand=0 SHALL take the overflow path (AC >= 0 always).
REQ-029 NMI SHALL shift AC:MQ left one step per clock until AC[0]!=AC[1], or AC:MQ=0, or AC:MQ=6000:0000 (octal).
REQ-030 NMI SHALL increment sc_out from 0 on each shift.
REQ-031 NMI with a load value already meeting its stop condition SHALL take one RUN cycle, perform no shift, and leave SC=0.
REQ-032 NMI SHALL leave L unchanged.
REQ-033 SC SHALL wrap modulo 32 where applicable.
REQ-034 A start accepted in DONE SHALL take priority over the DONE->IDLE return, and SHALL allow back-to-back operations.

Reset
REQ-035 Asserting reset, including mid-RUN, SHALL immediately force IDLE, busy=0, done=0, ac_out=mq_out=0, link_out=0 and sc_out=0.
REQ-036 Any operation in progress at reset SHALL be discarded.
REQ-037 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-038 SHL: AC=0000, MQ=0001, L=0, c=2 -> after 3 RUN cycles, done=1 with AC=0000, MQ=0010 and L=0.
REQ-039 ASR/LSR: AC=4000, MQ=0000, c=0 -> ASR gives AC=6000 and L=1; LSR gives AC=2000 and L=0.
REQ-040 MUY: AC=0000, MQ=0012, operand=0014 -> after 12 RUN cycles, AC=0000, MQ=0170 and L=0.
REQ-041 DVI: AC=0000, MQ=0144, operand=0007 -> MQ=0016, AC=0002, L=0; separately AC=0010, operand=0007 -> L=1 with AC/MQ unchanged after 1 RUN cycle.
REQ-042 NMI: AC=0000, MQ=0001 -> AC=2000, MQ=0000, SC=26 (octal) after 22 RUN cycles; separately AC:MQ=0 -> SC=0 after 1 RUN cycle.
REQ-043 Reset mid-MUY at step 5 -> all outputs 0, state IDLE; start during RUN is ignored; a start accepted in DONE begins the new operation on that edge.
